stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control front-end that sits directly upstream of the BCD stopwatch counter chain (MIN/TENSEC/SEC/DECISEC/CENTISEC).
- Synchronises and debounces two push-buttons, runs a start/stop/lap/clear state machine, and divides the system clock to a 100 Hz tick.
- Drives the stopwatch's ENABLE and clear inputs.
- Consumes the stopwatch's 20-bit packed TIME and outputs a display value that is either live or frozen for lap/split.

Parameters:
TICK_DIV, 500000, CLK cycles per centisecond tick (50 MHz / 100 Hz); minimum 2.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change; minimum 2.

Ports:
CLK  input  1  system clock, all state on rising edge.
RESET  input  1  asynchronous, active-low reset.
BTN_SS  input  1  start/stop button, raw and asynchronous, active-high.
BTN_LR  input  1  lap/reset button, raw and asynchronous, active-high.
TIME  input  20  packed BCD time from the stopwatch, {MIN,TENSEC,SEC,DECISEC,CENTISEC}.
ENABLE  output  1  count-enable to the stopwatch; one-cycle pulse per tick.
CLEAR  output  1  one-cycle active-high clear pulse to the stopwatch reset input.
DISP  output  20  time to display, in the same packing as TIME.
STATE  output  2  FSM state: 00 IDLE, 01 RUN, 10 LAP, 11 STOP.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, synchronisers=0, debounced levels=0, debounce counters=0, divider=0, lap register=0, CLEAR=0.
  - ENABLE=0 throughout reset.
  - DISP=TIME throughout reset.
- Synchroniser: each button passes through 2 flops before any other use.
- Debounce, per button:
  - Counter clears whenever the synchronised level equals the debounced level.
  - While the levels differ, the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- Press pulse: press = debounced & ~debounced_prev, combinational, exactly one cycle wide. Releases produce nothing.
- End-to-end latency: STATE updates on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples the button high.
- FSM, evaluated only on press pulses:
  - IDLE: SS -> RUN. LR is ignored.
  - RUN: SS -> STOP. LR -> LAP and the lap register captures TIME as present in that cycle, i.e. the pre-increment value if ENABLE is also high.
  - LAP: LR -> RUN, display returns to live. SS -> STOP, display returns to live.
  - STOP: SS -> RUN. LR -> IDLE and CLEAR is registered high for exactly the next cycle.
  - SS and LR pressed in the same cycle: SS wins and LR is discarded, with no lap capture and no CLEAR.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps to 0 while state is RUN or LAP.
  - Holds its value in STOP, so resuming keeps the phase.
  - Forced to 0 when CLEAR is asserted.
- ENABLE = (state is RUN or LAP) & (divider == TICK_DIV-1). Combinational from registered state, so it is never high in IDLE or STOP.
- Counting continues in LAP; only the display is frozen.
- DISP = lap register when state is LAP, else TIME. Combinational mux.
- Mid-operation reset: all outputs take their reset values immediately and asynchronously. An in-progress debounce is abandoned, so a held button must be re-qualified after release of reset.
- Width rules:
  - Counters are sized ceil(log2(param)) bits.
  - No saturation is needed; counters never exceed param-1.

Test Plan (bench uses TICK_DIV=5, DEBOUNCE_CYCLES=4):
1. Bounce rejection: BTN_SS toggles 1,0,1,0 with 2 cycles per level -> STATE stays 00. Then hold BTN_SS high -> STATE=01 on the 7th edge after the first high sample, with no second transition while held.
2. Tick generation: after entering RUN -> ENABLE high on the 5th cycle, then every 5th cycle, always 1 cycle wide. Over 50 cycles there are exactly 10 ENABLE pulses.
3. Lap freeze: in RUN, press LR while TIME=20'h01234 -> STATE=10 and DISP holds 20'h01234 while ENABLE keeps pulsing. Second LR press -> STATE=01 and DISP tracks TIME the same cycle.
4. Stop/resume/clear: SS in RUN with divider=3 -> STATE=11, ENABLE=0, divider holds at 3. SS again -> first ENABLE 2 cycles after re-entry to RUN. SS then LR -> CLEAR high exactly 1 cycle, STATE=00, divider=0.
5. Simultaneous press: in RUN, both buttons qualify on the same edge -> STATE=11, lap register unchanged, CLEAR stays 0.
6. Async reset mid-run: drop RESET between clock edges while in LAP -> STATE=00, ENABLE=0, DISP=TIME before the next edge. After RESET=1 with BTN_SS still held -> STATE=01 only after a full 7-edge re-qualification.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Purpose : button front-end, start/stop/lap/clear FSM and 100 Hz tick divider for a BCD stopwatch.
// Latency : a held button changes STATE on the (DEBOUNCE_CYCLES+3)th edge; ENABLE/DISP are combinational.
// Backpr. : none; ENABLE is a single-cycle strobe and the downstream counter must accept every one.
//
// Ports:
//   CLK, RESET       system clock, asynchronous active-low reset
//   BTN_SS, BTN_LR   raw asynchronous push-buttons (start/stop, lap/reset), active-high
//   TIME             packed BCD time from the counter chain {MIN,TENSEC,SEC,DECISEC,CENTISEC}
//   ENABLE           one-cycle count strobe per centisecond while running (RUN or LAP)
//   CLEAR            one-cycle clear pulse to the counter chain
//   DISP             live TIME, or the frozen lap value while in LAP
//   STATE            00 IDLE, 01 RUN, 10 LAP, 11 STOP
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_SS,
    input  logic        BTN_LR,
    input  logic [19:0] TIME,
    output logic        ENABLE,
    output logic        CLEAR,
    output logic [19:0] DISP,
    output logic [1:0]  STATE
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    // Bit 0 is the start/stop button, bit 1 the lap/reset button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [1:0]      deb_prev;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;
    logic            press_ss;
    logic            press_lr;

    state_t           state;
    logic [19:0]      lap_q;
    logic             clear_q;
    logic [DIV_W-1:0] div_q;
    logic             counting;
    logic             clear_set;

    assign btn_raw = {BTN_LR, BTN_SS};

    // Two-flop synchroniser, then a per-button stability counter: the
    // debounced level only follows the synchronised level after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            deb_prev  <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced level; releases are ignored.
    assign press    = deb & ~deb_prev;
    assign press_ss = press[0];
    assign press_lr = press[1];

    assign counting = (state == S_RUN) || (state == S_LAP);

    // A lap/reset press in STOP clears, unless start/stop wins the same cycle.
    assign clear_set = (state == S_STOP) && press_lr && !press_ss;

    // Start/stop always takes priority over lap/reset on a coincident press.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            lap_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= clear_set;
            case (state)
                S_IDLE: begin
                    if (press_ss) state <= S_RUN;
                end
                S_RUN: begin
                    if (press_ss) begin
                        state <= S_STOP;
                    end else if (press_lr) begin
                        state <= S_LAP;
                        lap_q <= TIME;  // value before any concurrent increment
                    end
                end
                S_LAP: begin
                    if (press_ss)      state <= S_STOP;
                    else if (press_lr) state <= S_RUN;
                end
                S_STOP: begin
                    if (press_ss)      state <= S_RUN;
                    else if (press_lr) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tick divider: free-runs while counting, holds in STOP so a resume keeps
    // its phase, and restarts from zero on a clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q <= '0;
        end else if (clear_set || clear_q) begin
            div_q <= '0;
        end else if (counting) begin
            if (div_q == DIV_MAX) div_q <= '0;
            else                  div_q <= div_q + 1'b1;
        end
    end

    assign ENABLE = counting && (div_q == DIV_MAX);
    assign CLEAR  = clear_q;
    assign DISP   = (state == S_LAP) ? lap_q : TIME;
    assign STATE  = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose : self-checking bench for stopwatch_ctrl (TICK_DIV=5, DEBOUNCE_CYCLES=4).
// Latency : compares every cycle against a reference model, plus directed checks.
// Backpr. : n/a.
module tb_stopwatch_ctrl;

    localparam int TD = 5;
    localparam int DB = 4;

    logic        CLK;
    logic        RESET;
    logic        BTN_SS;
    logic        BTN_LR;
    logic [19:0] TIME;
    logic        ENABLE;
    logic        CLEAR;
    logic [19:0] DISP;
    logic [1:0]  STATE;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl #(
        .TICK_DIV       (TD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .BTN_SS(BTN_SS),
        .BTN_LR(BTN_LR),
        .TIME  (TIME),
        .ENABLE(ENABLE),
        .CLEAR (CLEAR),
        .DISP  (DISP),
        .STATE (STATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: states 0 IDLE, 1 RUN, 2 LAP, 3 STOP.
    // A button is accepted once its synchronised level has disagreed with the
    // accepted level for the last DB samples in a row.
    int               m_state;
    logic [1:0]       m_s1;
    logic [1:0]       m_s2;
    logic [1:0]       m_deb;
    logic [1:0]       m_debp;
    logic [DB-1:0]    m_hist [2];
    int               m_phase;
    logic             m_clear;
    logic [19:0]      m_lap;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_s1      = '0;
        m_s2      = '0;
        m_deb     = '0;
        m_debp    = '0;
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_phase   = 0;
        m_clear   = 1'b0;
        m_lap     = '0;
    endtask

    // One clock: model computed from pre-edge inputs, DUT checked at negedge.
    task automatic step();
        logic [1:0]    raw;
        logic [1:0]    prs;
        logic [1:0]    n_deb;
        logic [DB-1:0] n_hist [2];
        int            n_state;
        int            n_phase;
        logic          n_clear;
        logic [19:0]   n_lap;
        logic          run_now;
        logic          exp_en;
        if (!RESET) begin
            @(posedge CLK);
            model_reset();
        end else begin
            raw   = {BTN_LR, BTN_SS};
            prs   = m_deb & ~m_debp;
            n_deb = m_deb;
            for (int b = 0; b < 2; b++) begin
                n_hist[b] = {m_hist[b][DB-2:0], m_s2[b]};
                if (n_hist[b] == {DB{~m_deb[b]}}) n_deb[b] = ~m_deb[b];
            end
            n_state = m_state;
            n_lap   = m_lap;
            n_clear = 1'b0;
            if (prs[0]) begin
                n_state = (m_state == 1 || m_state == 2) ? 3 : 1;
            end else if (prs[1]) begin
                if (m_state == 1) begin
                    n_state = 2;
                    n_lap   = TIME;
                end else if (m_state == 2) begin
                    n_state = 1;
                end else if (m_state == 3) begin
                    n_state = 0;
                    n_clear = 1'b1;
                end
            end
            run_now = (m_state == 1) || (m_state == 2);
            if (n_clear || m_clear) n_phase = 0;
            else if (run_now)       n_phase = (m_phase + 1) % TD;
            else                    n_phase = m_phase;
            @(posedge CLK);
            m_s2      = m_s1;
            m_s1      = raw;
            m_debp    = m_deb;
            m_deb     = n_deb;
            m_hist[0] = n_hist[0];
            m_hist[1] = n_hist[1];
            m_state   = n_state;
            m_lap     = n_lap;
            m_clear   = n_clear;
            m_phase   = n_phase;
        end
        @(negedge CLK);
        exp_en = ((m_state == 1) || (m_state == 2)) && (m_phase == TD - 1);
        chk("model_state", STATE, m_state);
        chk("model_enable", ENABLE, exp_en);
        chk("model_clear", CLEAR, m_clear);
        chk("model_disp", DISP, (m_state == 2) ? m_lap : TIME);
    endtask

    typedef struct {
        logic       ss;
        logic       lr;
        logic [1:0] st;
        logic       en;
    } vec_t;

    vec_t vt [30];

    initial begin
        int en_cnt;
        int en_hi;
        int first;
        int k;
        logic prev_en;

        // Bounce then hold: edges 1..8 toggle every 2 cycles, held high from
        // edge 9, so RUN appears on edge 15 and ticks on 19, 24, 29.
        for (int e = 1; e <= 30; e++) begin
            vt[e-1].ss = (e <= 8) ? ((((e - 1) / 2) % 2) == 0) : 1'b1;
            vt[e-1].lr = 1'b0;
            vt[e-1].st = (e >= 15) ? 2'b01 : 2'b00;
            vt[e-1].en = (e >= 19) && (((e - 19) % 5) == 0);
        end

        RESET  = 1'b0;
        BTN_SS = 1'b0;
        BTN_LR = 1'b0;
        TIME   = 20'h00042;
        #3;
        chk("rst_state", STATE, 2'b00);
        chk("rst_enable", ENABLE, 1'b0);
        chk("rst_clear", CLEAR, 1'b0);
        chk("rst_disp", DISP, 20'h00042);
        model_reset();
        repeat (2) step();
        RESET = 1'b1;

        // Bounce rejection and qualification latency.
        for (int i = 0; i < 30; i++) begin
            BTN_SS = vt[i].ss;
            BTN_LR = vt[i].lr;
            step();
            chk("tbl_state", STATE, vt[i].st);
            chk("tbl_enable", ENABLE, vt[i].en);
        end

        // Tick generation over 50 cycles while the button stays held.
        en_cnt  = 0;
        en_hi   = 0;
        prev_en = ENABLE;
        for (int i = 0; i < 50; i++) begin
            step();
            if (ENABLE === 1'b1) en_hi++;
            if (ENABLE === 1'b1 && prev_en !== 1'b1) en_cnt++;
            prev_en = ENABLE;
        end
        chk("tick_pulses", en_cnt, 10);
        chk("tick_hi_cycles", en_hi, 10);
        chk("tick_still_run", STATE, 2'b01);
        BTN_SS = 1'b0;
        repeat (8) step();

        // Lap freeze.
        TIME   = 20'h01234;
        BTN_LR = 1'b1;
        repeat (7) step();
        chk("lap_state", STATE, 2'b10);
        chk("lap_disp", DISP, 20'h01234);
        BTN_LR = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            TIME = 20'($urandom);
            step();
            chk("lap_frozen", DISP, 20'h01234);
            if (ENABLE === 1'b1) en_cnt++;
        end
        chk("lap_ticks", en_cnt, 4);
        BTN_LR = 1'b1;
        repeat (7) step();
        chk("unlap_state", STATE, 2'b01);
        TIME = 20'h56789;
        #1;
        chk("unlap_live", DISP, 20'h56789);
        BTN_LR = 1'b0;
        repeat (8) step();

        // Stop with divider at 3, resume keeps phase.
        k = 0;
        while (ENABLE !== 1'b1 && k < 12) begin
            step();
            k++;
        end
        chk("t4_align", ENABLE, 1'b1);
        repeat (2) step();
        BTN_SS = 1'b1;
        repeat (7) step();
        chk("stop_state", STATE, 2'b11);
        chk("stop_enable", ENABLE, 1'b0);
        BTN_SS = 1'b0;
        en_cnt = 0;
        repeat (8) begin
            step();
            if (ENABLE === 1'b1) en_cnt++;
        end
        chk("stop_ticks", en_cnt, 0);
        BTN_SS = 1'b1;
        repeat (7) step();
        chk("resume_state", STATE, 2'b01);
        chk("resume_c1", ENABLE, 1'b0);
        step();
        chk("resume_c2", ENABLE, 1'b1);
        BTN_SS = 1'b0;
        repeat (8) step();

        // Stop then clear.
        BTN_SS = 1'b1;
        repeat (7) step();
        chk("stop2_state", STATE, 2'b11);
        BTN_SS = 1'b0;
        repeat (8) step();
        BTN_LR = 1'b1;
        repeat (7) step();
        chk("clr_state", STATE, 2'b00);
        chk("clr_pulse", CLEAR, 1'b1);
        chk("clr_enable", ENABLE, 1'b0);
        step();
        chk("clr_one_cycle", CLEAR, 1'b0);
        BTN_LR = 1'b0;
        repeat (7) step();
        BTN_SS = 1'b1;
        repeat (7) step();
        chk("restart_state", STATE, 2'b01);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (ENABLE === 1'b1 && first == 0) first = i + 1;
        end
        chk("clr_phase", first, 5);
        BTN_SS = 1'b0;
        repeat (8) step();

        // Simultaneous press in RUN: start/stop wins.
        BTN_SS = 1'b1;
        BTN_LR = 1'b1;
        repeat (7) step();
        chk("both_state", STATE, 2'b11);
        chk("both_clear0", CLEAR, 1'b0);
        step();
        chk("both_clear1", CLEAR, 1'b0);
        BTN_SS = 1'b0;
        BTN_LR = 1'b0;
        repeat (8) step();

        // Async reset while in LAP with start/stop held.
        BTN_SS = 1'b1;
        repeat (7) step();
        BTN_SS = 1'b0;
        repeat (8) step();
        BTN_LR = 1'b1;
        repeat (7) step();
        chk("pre_rst_lap", STATE, 2'b10);
        BTN_LR = 1'b0;
        repeat (8) step();
        BTN_SS = 1'b1;
        repeat (2) step();
        #2;
        RESET = 1'b0;
        TIME  = 20'hABCDE;
        #1;
        chk("arst_state", STATE, 2'b00);
        chk("arst_enable", ENABLE, 1'b0);
        chk("arst_clear", CLEAR, 1'b0);
        chk("arst_disp", DISP, 20'hABCDE);
        model_reset();
        repeat (3) step();
        RESET = 1'b1;
        repeat (6) step();
        chk("requal_wait", STATE, 2'b00);
        step();
        chk("requal_run", STATE, 2'b01);
        BTN_SS = 1'b0;
        repeat (8) step();

        // Randomised segments against the model.
        for (int seg = 0; seg < 250; seg++) begin
            BTN_SS = 1'($urandom_range(0, 1));
            BTN_LR = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                #2;
                RESET = 1'b0;
                #1;
                model_reset();
                chk("rnd_arst_state", STATE, 2'b00);
                chk("rnd_arst_enable", ENABLE, 1'b0);
                repeat (2) step();
                RESET = 1'b1;
            end
            k = $urandom_range(1, 12);
            for (int c = 0; c < k; c++) begin
                TIME = 20'($urandom);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
